// File: rtl/ula_sequenciador.sv
// ALU control sequencer: IDLE -> LOAD_A -> LOAD_B -> EXEC(xN) -> WRITE -> DONE.
// Optional accumulator mode (operand A taken from the result register) is built with `define ULA_SEQ_ACC_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; no enables, busy low
// LOAD_A   | en_a for one cycle (skipped in accumulator mode)
// LOAD_B   | en_b for one cycle; loads the EXEC down-counter
// EXEC     | ALU settling, EXEC_CYCLES cycles
// WRITE    | en_res; flags_q and op_count update on the closing edge
// DONE     | one-cycle done pulse, then back to IDLE
module ula_sequenciador #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] opcode,
  input  logic       use_acc,
  input  logic [3:0] alu_flags,
  output logic       en_a,
  output logic       en_b,
  output logic       en_res,
  output logic       mux_a_sel,
  output logic [2:0] op_q,
  output logic [3:0] flags_q,
  output logic       busy,
  output logic       done,
  output logic [7:0] op_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] exec_cnt_q, exec_cnt_d;
  logic       acc_q, acc_d;
  logic [2:0] op_d;
  logic [3:0] flags_d;
  logic [7:0] count_d;
  logic       acc_req;

`ifdef ULA_SEQ_ACC_EN
  assign acc_req = use_acc;
`else
  logic unused_use_acc;
  assign unused_use_acc = use_acc;
  assign acc_req        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    exec_cnt_d = exec_cnt_q;
    acc_d      = acc_q;
    op_d       = op_q;
    flags_d    = flags_q;
    count_d    = op_count;
    // abort wins everywhere outside IDLE, so WRITE never commits flags/count
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            op_d    = opcode;
            acc_d   = acc_req;
            state_d = acc_req ? S_LOAD_B : S_LOAD_A;
          end
        end
        S_LOAD_A: state_d = S_LOAD_B;
        S_LOAD_B: begin
          exec_cnt_d = EXEC_LAST;
          state_d    = S_EXEC;
        end
        S_EXEC: begin
          if (exec_cnt_q == 4'd0) state_d = S_WRITE;
          else                    exec_cnt_d = exec_cnt_q - 4'd1;
        end
        S_WRITE: begin
          flags_d = alu_flags;
          count_d = op_count + 8'd1;
          state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      exec_cnt_q <= 4'd0;
      acc_q      <= 1'b0;
      op_q       <= 3'd0;
      flags_q    <= 4'd0;
      op_count   <= 8'd0;
    end else begin
      state_q    <= state_d;
      exec_cnt_q <= exec_cnt_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      flags_q    <= flags_d;
      op_count   <= count_d;
    end
  end

  assign en_a   = (state_q == S_LOAD_A);
  assign en_b   = (state_q == S_LOAD_B);
  assign en_res = (state_q == S_WRITE);
  assign done   = (state_q == S_DONE);
  assign busy   = (state_q != S_IDLE);

`ifdef ULA_SEQ_ACC_EN
  assign mux_a_sel = acc_q && ((state_q == S_LOAD_B) || (state_q == S_EXEC) ||
                               (state_q == S_WRITE));
`else
  assign mux_a_sel = 1'b0;
`endif

endmodule
